// File: rtl/imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// imm_ext_pipe
//
// Purpose:
//   Pipelined immediate-extension unit for the decode stage. A raw instruction
//   immediate is extended combinationally according to in_op, and the result
//   is stored in a 2-entry valid/ready skid buffer. The buffer has a main
//   register that drives the outputs and a skid register that holds one extra
//   entry. Because of the skid entry, in_ready depends only on registered state.
//   A sideband tag travels with each result.
//
// Parameters:
//   IMM_W   raw immediate width (>= 8)
//   DATA_W  result width (DATA_W > IMM_W, DATA_W >= IMM_W + SHAMT)
//   SHAMT   left shift applied in the branch-offset mode
//   TAG_W   sideband tag width (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   producer offers an operand
//   in_ready   unit can accept (state != FULL)
//   in_imm     raw immediate
//   in_op      extension mode: 0 SEXT, 1 ZEXT, 2 HIGH, 3 BOFF, 4 SBYTE,
//              5 ZBYTE, 6/7 undefined (result 0)
//   in_tag     sideband tag, passed through unchanged
//   out_valid  result available
//   out_ready  consumer takes the result
//   out_data   extended operand
//   out_tag    tag of the result
//   out_err    undefined-op flag (only when IMM_EXT_ERR_EN is defined)
//
// Build option:
//   IMM_EXT_ERR_EN  adds the out_err port. Ops 6/7 then raise out_err, and
//                   the flag travels with its entry.
// -----------------------------------------------------------------------------
module imm_ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int SHAMT  = 2,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [2:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
`ifdef IMM_EXT_ERR_EN
  ,
  output logic              out_err
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [TAG_W-1:0]  main_tag_q,  main_tag_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0]  skid_tag_q,  skid_tag_d;
`ifdef IMM_EXT_ERR_EN
  logic              main_err_q,  main_err_d;
  logic              skid_err_q,  skid_err_d;
  logic              ext_err;
`endif

  logic              accept;
  logic [DATA_W-1:0] ext_data;

  // Extension rules. The undefined ops 6/7 fall through to zero.
  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                input logic [2:0]       op);
    logic signed [DATA_W-1:0] sx;
    logic [DATA_W-1:0]        res;
    sx  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    res = '0;
    case (op)
      3'd0:    res = sx;
      3'd1:    res = {{(DATA_W-IMM_W){1'b0}}, imm};
      3'd2:    res = {imm, {(DATA_W-IMM_W){1'b0}}};
      3'd3:    res = sx <<< SHAMT;
      3'd4:    res = {{(DATA_W-8){imm[7]}}, imm[7:0]};
      3'd5:    res = {{(DATA_W-8){1'b0}}, imm[7:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign ext_data  = ext_imm(in_imm, in_op);
  assign out_data  = main_data_q;
  assign out_tag   = main_tag_q;
`ifdef IMM_EXT_ERR_EN
  assign ext_err   = in_op[2] & in_op[1];
  assign out_err   = main_err_q;
`endif

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_tag_d  = main_tag_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
`ifdef IMM_EXT_ERR_EN
    main_err_d  = main_err_q;
    skid_err_d  = skid_err_q;
`endif
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_data_d = ext_data;
          main_tag_d  = in_tag;
`ifdef IMM_EXT_ERR_EN
          main_err_d  = ext_err;
`endif
        end
      end
      ONE: begin
        if (accept && out_ready) begin
          // Current entry leaves while the new one replaces it.
          main_data_d = ext_data;
          main_tag_d  = in_tag;
`ifdef IMM_EXT_ERR_EN
          main_err_d  = ext_err;
`endif
        end else if (accept) begin
          // The consumer is stalled, so the new entry parks in the skid slot.
          state_d     = FULL;
          skid_data_d = ext_data;
          skid_tag_d  = in_tag;
`ifdef IMM_EXT_ERR_EN
          skid_err_d  = ext_err;
`endif
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_tag_d  = skid_tag_q;
          skid_data_d = '0;
          skid_tag_d  = '0;
`ifdef IMM_EXT_ERR_EN
          main_err_d  = skid_err_q;
          skid_err_d  = 1'b0;
`endif
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_tag_q  <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
`ifdef IMM_EXT_ERR_EN
      main_err_q  <= 1'b0;
      skid_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_tag_q  <= main_tag_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
`ifdef IMM_EXT_ERR_EN
      main_err_q  <= main_err_d;
      skid_err_q  <= skid_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_ext_pipe
//
// Self-checking bench for imm_ext_pipe with default parameters. The reference
// model is a FIFO of at most two expected entries. Each expected value is
// computed with plain integer arithmetic from the extension rules.
// -----------------------------------------------------------------------------
module tb_imm_ext_pipe;

  localparam int IW = 16;
  localparam int DW = 32;
  localparam int SH = 2;
  localparam int TW = 5;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_imm;
  logic [2:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
`ifdef IMM_EXT_ERR_EN
  logic          out_err;
`endif

  imm_ext_pipe #(.IMM_W(IW), .DATA_W(DW), .SHAMT(SH), .TAG_W(TW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef IMM_EXT_ERR_EN
    ,
    .out_err   (out_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic          e;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference extension from integer arithmetic: interpret, scale, wrap to DW.
  function automatic logic [DW-1:0] model_ext(input logic [IW-1:0] imm,
                                              input logic [2:0] op);
    longint u, s, b, sb, r;
    u  = longint'(imm);
    s  = (u >= (longint'(1) << (IW-1))) ? u - (longint'(1) << IW) : u;
    b  = u % 256;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      3'd0:    r = s;
      3'd1:    r = u;
      3'd2:    r = u * (longint'(1) << (DW-IW));
      3'd3:    r = s * (longint'(1) << SH);
      3'd4:    r = sb;
      3'd5:    r = b;
      default: r = 0;
    endcase
    return r[DW-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge. It checks the outputs against the model,
  // advances the model by one clock and returns #1 after the next edge.
  task automatic cyc();
    ent_t e;
    logic acc, emt;
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_data", 64'(out_data), 64'(q[0].d));
      check("out_tag", 64'(out_tag), 64'(q[0].t));
`ifdef IMM_EXT_ERR_EN
      check("out_err", 64'(out_err), 64'(q[0].e));
`endif
    end
    acc = in_valid && (q.size() < 2);
    emt = (q.size() != 0) && out_ready;
    e.d = model_ext(in_imm, in_op);
    e.t = in_tag;
    e.e = (in_op >= 3'd6);
    if (emt) void'(q.pop_front());
    if (acc) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Offers one entry for one cycle with out_ready high.
  // After the accept edge, out_data is checked against a literal.
  task automatic mode_chk(input string tag, input logic [2:0] op,
                          input logic [IW-1:0] imm, input logic [DW-1:0] exp);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_imm    = imm;
    in_tag    = 5'd3;
    cyc();
    in_valid  = 1'b0;
    check(tag, 64'(out_data), 64'(exp));
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Extension modes.
    mode_chk("sext",  3'd0, 16'h8000, 32'hFFFF8000);
    mode_chk("zext",  3'd1, 16'h8000, 32'h00008000);
    mode_chk("high",  3'd2, 16'h1234, 32'h12340000);
    mode_chk("boff_n", 3'd3, 16'hFFFF, 32'hFFFFFFFC);
    mode_chk("boff_p", 3'd3, 16'h0001, 32'h00000004);
    mode_chk("sbyte", 3'd4, 16'h0080, 32'hFFFFFF80);
    mode_chk("zbyte", 3'd5, 16'h1280, 32'h00000080);
    mode_chk("op6_data", 3'd6, 16'h7FFF, 32'h00000000);
`ifdef IMM_EXT_ERR_EN
    check("op6_err", 64'(out_err), 64'd1);
    mode_chk("op0_data", 3'd0, 16'h0005, 32'h00000005);
    check("op0_err", 64'(out_err), 64'd0);
`endif
    cyc();

    // Streaming: 8 back-to-back results, tag visible one cycle after accept.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_op    = 3'd1;
      in_imm   = 16'(i * 16'h0101);
      in_tag   = 5'(i);
      cyc();
      check("stream_tag", 64'(out_tag), 64'(i));
    end
    in_valid = 1'b0;
    cyc();
    check("stream_drained", 64'(out_valid), 64'd0);

    // Backpressure: A and B fill the buffer and C waits.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_op = 3'd0; in_imm = 16'hA00A; in_tag = 5'd1;
    cyc();
    in_imm = 16'hB00B; in_tag = 5'd2;
    cyc();
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    in_imm = 16'hC00C; in_tag = 5'd3;
    for (int i = 0; i < 3; i++) cyc();
    check("bp_hold_tag", 64'(out_tag), 64'd1);
    out_ready = 1'b1;
    cyc();
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    check("bp_empty", 64'(q.size()), 64'd0);

    // Reset mid-operation from FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_op = 3'd2; in_imm = 16'h5555; in_tag = 5'd7;
    cyc();
    cyc();
    in_valid = 1'b0;
    check("pre_rst_full", 64'(in_ready), 64'd0);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_imm    = 16'($urandom);
      in_tag    = 5'($urandom);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    check("final_empty", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
